// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared types and constants for the data memory arbiter
package dm_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_HOLD   = 3'd2,
      ST_ACK    = 3'd3,
      ST_ERR    = 3'd4
   } arb_state_t;

   localparam int DW_BYTES      = 8;
   localparam int MEM_BYTES_DEF = 256;

   // Low address bits that must be zero for a doubleword access.
   localparam logic [2:0] ALIGN_MASK = 3'(DW_BYTES - 1);

endpackage

// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - requester, memory and status signals of the data memory arbiter
interface data_memory_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);

   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic              m0_err;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic              m1_err;
   logic [DATA_W-1:0] m1_rdata;

   logic              dm_MemRead;
   logic              dm_MemWrite;
   logic [ADDR_W-1:0] dm_Address;
   logic [DATA_W-1:0] dm_WriteData;
   logic [DATA_W-1:0] dm_ReadData;

   logic              busy;
   logic [7:0]        err_count;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ack, m0_err, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ack, m1_err, m1_rdata,
      output dm_MemRead, dm_MemWrite, dm_Address, dm_WriteData,
      input  dm_ReadData,
      output busy, err_count
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ack, m0_err, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ack, m1_err, m1_rdata,
      input  dm_MemRead, dm_MemWrite, dm_Address, dm_WriteData,
      output dm_ReadData,
      input  busy, err_count
   );

endinterface

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
// rtl/data_memory_arbiter_rr_arbiter_2.sv - two-way round-robin grant selection
module rr_arbiter_2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       gnt_o,
   output logic       valid_o
);

   // On contention the port that was not served last wins.
   always_comb begin
      valid_o = |req_i;
      gnt_o   = 1'b0;
      if (req_i == 2'b11) begin
         gnt_o = ~last_i;
      end else begin
         gnt_o = req_i[1];
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin two-port front end for the 64-bit data memory
module data_memory_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic                 clock,
   input  logic                 reset_n,
   data_memory_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_DW = ADDR_W'(MEM_BYTES - DW_BYTES);

   arb_state_t        state_q, state_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [1:0]        ack_q, ack_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
   logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
   logic              busy_q, busy_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              arb_gnt;
   logic              arb_valid;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_ok;

   rr_arbiter_2 u_rr (
      .req_i   ({bus.m1_req, bus.m0_req}),
      .last_i  (last_q),
      .gnt_o   (arb_gnt),
      .valid_o (arb_valid)
   );

   // Upper bound compare covers both high address bits and the top of memory without wrap.
   always_comb begin
      sel_we    = arb_gnt ? bus.m1_we    : bus.m0_we;
      sel_addr  = arb_gnt ? bus.m1_addr  : bus.m0_addr;
      sel_wdata = arb_gnt ? bus.m1_wdata : bus.m0_wdata;
      sel_ok    = ((sel_addr[2:0] & ALIGN_MASK) == 3'b000) && (sel_addr <= LAST_DW);
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ack_d      = 2'b00;
      err_d      = 2'b00;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      err_cnt_d  = err_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               gnt_d   = arb_gnt;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               if (sel_ok) begin
                  state_d    = ST_ACCESS;
                  dm_addr_d  = sel_addr;
                  wr_d       = sel_we;
                  rd_d       = ~sel_we;
                  dm_wdata_d = sel_we ? sel_wdata : '0;
               end else begin
                  state_d        = ST_ERR;
                  ack_d[arb_gnt] = 1'b1;
                  err_d[arb_gnt] = 1'b1;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end
            end
         end
         ST_ACCESS: begin
            state_d = ST_HOLD;
            wr_d    = 1'b0;
         end
         ST_HOLD: begin
            // Read data is sampled on the closing edge of HOLD, one cycle after the address settled.
            state_d      = ST_ACK;
            rd_d         = 1'b0;
            wr_d         = 1'b0;
            dm_addr_d    = '0;
            dm_wdata_d   = '0;
            ack_d[gnt_q] = 1'b1;
            if (!we_q) begin
               if (gnt_q) begin
                  rdata1_d = bus.dm_ReadData;
               end else begin
                  rdata0_d = bus.dm_ReadData;
               end
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            last_d  = gnt_q;
         end
         ST_ERR: begin
            state_d = ST_IDLE;
            last_d  = gnt_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ack_q      <= 2'b00;
         err_q      <= 2'b00;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         busy_q     <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         busy_q     <= busy_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.m0_ack       = ack_q[0];
   assign bus.m0_err       = err_q[0];
   assign bus.m0_rdata     = rdata0_q;
   assign bus.m1_ack       = ack_q[1];
   assign bus.m1_err       = err_q[1];
   assign bus.m1_rdata     = rdata1_q;
   assign bus.dm_MemRead   = rd_q;
   assign bus.dm_MemWrite  = wr_q;
   assign bus.dm_Address   = dm_addr_q;
   assign bus.dm_WriteData = dm_wdata_q;
   assign bus.busy         = busy_q;
   assign bus.err_count    = err_cnt_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   int   tests   = 0;
   int   fails   = 0;

   always #5 clock = ~clock;

   data_memory_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   data_memory_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(256)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Environment memory: big-endian, commits on the rising edge, combinational read.
   logic [7:0] mem [256];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 80; i < 88; i++) mem[i] = 8'hAA;
   end

   always @(posedge clock) begin
      if (bus.dm_MemWrite && bus.dm_Address <= 64'd248) begin
         for (int i = 0; i < 8; i++) begin
            mem[int'(bus.dm_Address[7:0]) + i] <= bus.dm_WriteData[63-8*i -: 8];
         end
      end
   end

   always_comb begin
      bus.dm_ReadData = '0;
      if (bus.dm_MemRead && bus.dm_Address <= 64'd248) begin
         for (int i = 0; i < 8; i++) begin
            bus.dm_ReadData[63-8*i -: 8] = mem[int'(bus.dm_Address[7:0]) + i];
         end
      end
   end

   // Reference model state.
   logic [7:0]  smem [256];
   int          m_last;
   int          m_errcnt;
   logic [63:0] m_rdata [2];

   function automatic bit addr_ok(input logic [63:0] a);
      return (a % 64'd8 == 64'd0) && (a <= 64'd248);
   endfunction

   function automatic logic [63:0] srd(input logic [63:0] a);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[55:0], smem[int'(a[7:0]) + i]};
      return v;
   endfunction

   function automatic logic [63:0] envrd(input logic [63:0] a);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[55:0], mem[int'(a[7:0]) + i]};
      return v;
   endfunction

   function automatic logic [63:0] bad_addr();
      logic [63:0] a;
      case ($urandom_range(0, 4))
         0:       a = 64'(8 * $urandom_range(0, 31) + $urandom_range(1, 7));
         1:       a = 64'(256 + 8 * $urandom_range(0, 200));
         2:       a = (64'd1 << $urandom_range(8, 63)) | 64'(8 * $urandom_range(0, 31));
         3:       a = 64'hFFFF_FFFF_FFFF_FFF8;
         default: a = 64'd249;
      endcase
      return a;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last     = 1;
      m_errcnt   = 0;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_ctl", {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err, bus.busy,
                      bus.dm_MemRead, bus.dm_MemWrite}, 64'd0);
      chk("rst_errcnt", bus.err_count, 64'd0);
      chk("rst_addr", bus.dm_Address, 64'd0);
      chk("rst_wdata", bus.dm_WriteData, 64'd0);
      chk("rst_rdata0", bus.m0_rdata, 64'd0);
      chk("rst_rdata1", bus.m1_rdata, 64'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      @(negedge clock);
   endtask

   // Issues up to two requests in the same cycle and checks timing, flags and data against the model.
   task automatic run_pair(input bit e0, input bit w0, input logic [63:0] a0, input logic [63:0] d0,
                           input bit e1, input bit w1, input logic [63:0] a1, input logic [63:0] d1);
      bit          en [2];
      bit          we [2];
      logic [63:0] ad [2];
      bit          pend [2];
      int          exp_cyc [2];
      int          got_cyc [2];
      bit          got_err [2];
      int          first, second, spurious, strobes, writes, exp_strobes, exp_writes;
      int          order [2];
      en = '{e0, e1}; we = '{w0, w1}; ad = '{a0, a1};
      if (e0 && e1) first = (m_last == 0) ? 1 : 0;
      else          first = e0 ? 0 : 1;
      second = 1 - first;
      exp_cyc[first] = addr_ok(ad[first]) ? 3 : 1;
      exp_cyc[second] = exp_cyc[first] + 1 + (addr_ok(ad[second]) ? 3 : 1);
      got_cyc = '{-1, -1};
      got_err = '{1'b0, 1'b0};
      pend = en;
      spurious = 0; strobes = 0; writes = 0;

      bus.m0_req = e0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
      bus.m1_req = e1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
      for (int c = 1; c <= 24 && (pend[0] || pend[1]); c++) begin
         @(negedge clock);
         if (bus.dm_MemWrite || bus.dm_MemRead) strobes++;
         if (bus.dm_MemWrite) writes++;
         if (bus.m0_ack) begin
            if (pend[0]) begin
               got_cyc[0] = c; got_err[0] = bus.m0_err; pend[0] = 1'b0; bus.m0_req = 1'b0;
            end else spurious++;
         end
         if (bus.m1_ack) begin
            if (pend[1]) begin
               got_cyc[1] = c; got_err[1] = bus.m1_err; pend[1] = 1'b0; bus.m1_req = 1'b0;
            end else spurious++;
         end
      end
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      @(negedge clock);
      if (bus.m0_ack || bus.m1_ack) spurious++;

      order = '{first, second};
      exp_strobes = 0; exp_writes = 0;
      foreach (order[k]) begin
         int p = order[k];
         if (en[p]) begin
            if (addr_ok(ad[p])) begin
               if (we[p]) begin
                  for (int i = 0; i < 8; i++) smem[int'(ad[p][7:0]) + i] = (p == 0 ? d0 : d1) >> (56 - 8*i);
                  exp_strobes += 1; exp_writes += 1;
               end else begin
                  m_rdata[p] = srd(ad[p]);
                  exp_strobes += 2;
               end
            end else if (m_errcnt < 255) m_errcnt++;
            m_last = p;
         end
      end

      for (int p = 0; p < 2; p++) begin
         if (en[p]) begin
            chk($sformatf("ack_cycle_p%0d", p), got_cyc[p], exp_cyc[p]);
            chk($sformatf("err_flag_p%0d", p), got_err[p], !addr_ok(ad[p]));
            if (addr_ok(ad[p]) && we[p]) chk("mem_commit", envrd(ad[p]), srd(ad[p]));
         end
      end
      chk("rdata0", bus.m0_rdata, m_rdata[0]);
      chk("rdata1", bus.m1_rdata, m_rdata[1]);
      chk("err_count", bus.err_count, m_errcnt);
      chk("spurious_ack", spurious, 0);
      chk("strobe_cycles", strobes, exp_strobes);
      chk("write_cycles", writes, exp_writes);
      chk("busy_idle", bus.busy, 0);
   endtask

   initial begin
      logic [63:0] pat;
      int          t1, t2, nack, ackseen;
      bit          e0, e1;

      for (int i = 0; i < 256; i++) smem[i] = 8'h00;
      for (int i = 80; i < 88; i++) smem[i] = 8'hAA;
      bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
      #2;
      apply_reset();

      run_pair(0, 0, 0, 0, 1, 0, 64'd80, 0);
      chk("m1_read80", bus.m1_rdata, 64'hAAAA_AAAA_AAAA_AAAA);

      apply_reset();
      run_pair(1, 0, 64'd80, 0, 1, 0, 64'd80, 0);
      run_pair(1, 0, 64'd88, 0, 1, 0, 64'd80, 0);

      pat = 64'h1122_3344_5566_7788;
      run_pair(1, 1, 64'd40, pat, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) chk("mem40_byte", mem[40 + i], pat[63-8*i -: 8]);
      run_pair(1, 0, 64'd40, 0, 0, 0, 0, 0);
      chk("m0_read40", bus.m0_rdata, pat);

      run_pair(1, 1, 64'd43, 64'hDEAD, 0, 0, 0, 0);
      chk("err_count_1", bus.err_count, 64'd1);
      run_pair(0, 0, 0, 0, 1, 0, 64'd256, 0);
      chk("err_count_2", bus.err_count, 64'd2);
      run_pair(1, 0, 64'd248, 0, 1, 0, 64'd249, 0);

      // Back-to-back: m0 keeps req high through ack and moves to address 48.
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 64'd40;
      t1 = -1; t2 = -1; nack = 0;
      for (int c = 1; c <= 24 && nack < 2; c++) begin
         @(negedge clock);
         if (bus.m0_ack) begin
            nack++;
            if (nack == 1) begin t1 = c; bus.m0_addr = 64'd48; end
            else begin t2 = c; bus.m0_req = 0; end
         end
      end
      bus.m0_req = 0;
      @(negedge clock);
      m_rdata[0] = srd(64'd48);
      m_last = 0;
      chk("b2b_first", t1, 3);
      chk("b2b_gap", t2 - t1, 4);
      chk("b2b_rdata", bus.m0_rdata, m_rdata[0]);

      for (int n = 0; n < 60; n++) begin
         logic [63:0] ra0, ra1;
         e0 = 1'($urandom_range(0, 1));
         e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
         ra0 = ($urandom_range(0, 9) < 7) ? 64'(8 * $urandom_range(1, 31)) : bad_addr();
         ra1 = ($urandom_range(0, 9) < 7) ? 64'(8 * $urandom_range(1, 31)) : bad_addr();
         run_pair(e0, 1'($urandom_range(0, 1)), ra0, {$urandom, $urandom},
                  e1, 1'($urandom_range(0, 1)), ra1, {$urandom, $urandom});
      end

      // Reset lands in the ACCESS cycle of a write to address 0.
      bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 64'd0; bus.m0_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clock);
      #2;
      chk("midrst_pre_wr", bus.dm_MemWrite, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_wr", bus.dm_MemWrite, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_ack", bus.m0_ack, 0);
      bus.m0_req = 0;
      ackseen = 0;
      repeat (3) begin @(negedge clock); if (bus.m0_ack || bus.m1_ack) ackseen++; end
      reset_n = 1'b1;
      model_reset();
      repeat (2) begin @(negedge clock); if (bus.m0_ack || bus.m1_ack) ackseen++; end
      chk("midrst_noack", ackseen, 0);
      chk("midrst_mem0", envrd(64'd0), 64'd0);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 1) == 0) run_pair(1, 1'($urandom_range(0, 1)), bad_addr(), 64'd5, 0, 0, 0, 0);
         else                           run_pair(0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), bad_addr(), 64'd6);
      end
      chk("err_count_sat", bus.err_count, 64'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
